// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two client request/read-return channels plus
// the single-port memory side. The arbiter uses the slave modport; the
// environment (clients + memory) uses the master modport.
//
// Handshake: a client presents cN_rts together with its request fields; the
// request transfers on a rising edge where cN_rts and cN_rtr are both 1, and
// the fields are sampled only on that edge. cN_rtr is combinational from the
// arbiter state and both rts inputs, so a client may raise or drop rts freely
// while it has not been granted.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  localparam int BW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] c0_data,    c1_data;
  logic [ADDR_WIDTH-1:0] c0_addr,    c1_addr;
  logic [BW-1:0]         c0_wben,    c1_wben;
  logic                  c0_op,      c1_op;
  logic                  c0_rts,     c1_rts;
  logic                  c0_rtr,     c1_rtr;
  logic [DATA_WIDTH-1:0] c0_rd_data, c1_rd_data;
  logic                  c0_rd_valid, c1_rd_valid;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BW-1:0]         mem_wben;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  c0_data, c0_addr, c0_wben, c0_op, c0_rts,
    input  c1_data, c1_addr, c1_wben, c1_op, c1_rts,
    output c0_rtr, c0_rd_data, c0_rd_valid,
    output c1_rtr, c1_rd_data, c1_rd_valid,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wben,
    input  mem_rdata
  );

  modport master (
    output c0_data, c0_addr, c0_wben, c0_op, c0_rts,
    output c1_data, c1_addr, c1_wben, c1_op, c1_rts,
    input  c0_rtr, c0_rd_data, c0_rd_valid,
    input  c1_rtr, c1_rd_data, c1_rd_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wben,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a single-port memory with a
// one-cycle read latency. One request is in flight at a time:
//   IDLE -> ISSUE (memory strobe) -> IDLE            for writes
//   IDLE -> ISSUE -> RD_WAIT -> IDLE                 for reads
// Configuration macro MEM_ARBITER_READ_EN: when defined, reads access memory
// and return data to the requesting client; when undefined, reads are
// accepted and dropped without touching memory, and read-return outputs are 0.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_,
  mem_arbiter_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int BW = DATA_WIDTH / 8;

`ifdef MEM_ARBITER_READ_EN
  localparam bit READ_PATH = 1'b1;
`else
  localparam bit READ_PATH = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [BW-1:0]         wben_q;
  logic                  op_q;
  logic                  id_q;
  logic                  last_grant_q;  // client granted most recently
  logic                  grant0, grant1, xfer;

  // Round-robin grant: only in IDLE and out of reset; on a tie the client
  // that was not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && rst_) begin
      if (bus.c0_rts && bus.c1_rts) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = bus.c0_rts;
        grant1 = bus.c1_rts;
      end
    end
  end

  assign xfer = grant0 | grant1;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_d = ISSUE;
      ISSUE:   state_d = (op_q || !READ_PATH) ? IDLE : RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and request capture on a transfer edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      wben_q       <= '0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        addr_q       <= grant1 ? bus.c1_addr : bus.c0_addr;
        data_q       <= grant1 ? bus.c1_data : bus.c0_data;
        wben_q       <= grant1 ? bus.c1_wben : bus.c0_wben;
        op_q         <= grant1 ? bus.c1_op   : bus.c0_op;
        id_q         <= grant1;
        last_grant_q <= grant1;
      end
    end
  end

  assign bus.c0_rtr    = grant0;
  assign bus.c1_rtr    = grant1;
  assign bus.mem_en    = (state_q == ISSUE) && (op_q || READ_PATH);
  assign bus.mem_we    = (state_q == ISSUE) && op_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = data_q;
  assign bus.mem_wben  = op_q ? wben_q : '0;
  assign dbg_state     = state_q;

`ifdef MEM_ARBITER_READ_EN
  logic [DATA_WIDTH-1:0] rd_data0_q, rd_data1_q;
  logic                  rd_valid0_q, rd_valid1_q;

  // Capture memory read data during RD_WAIT and strobe the owning client.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
    end else begin
      rd_valid0_q <= (state_q == RD_WAIT) && !id_q;
      rd_valid1_q <= (state_q == RD_WAIT) &&  id_q;
      if (state_q == RD_WAIT) begin
        if (id_q) rd_data1_q <= bus.mem_rdata;
        else      rd_data0_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.c0_rd_data  = rd_data0_q;
  assign bus.c1_rd_data  = rd_data1_q;
  assign bus.c0_rd_valid = rd_valid0_q;
  assign bus.c1_rd_valid = rd_valid1_q;
`else
  logic unused_rdata;
  assign unused_rdata    = ^bus.mem_rdata;
  assign bus.c0_rd_data  = '0;
  assign bus.c1_rd_data  = '0;
  assign bus.c0_rd_valid = 1'b0;
  assign bus.c1_rd_valid = 1'b0;
`endif

endmodule
